i1_req_scheduler: RTL and testbench
===================================

// Module: i1_req_scheduler
// PURPOSE
//   Round-robin scheduler for the seven request lines that feed the i1 decode logic.
//   Grants the shared decode path to exactly one requester at a time.
//   Bounds each grant with a hold limit, then inserts a programmable cooldown.
//   Sits ahead of the combinational i1 block: the one-hot grant drives its request
//   inputs, and en drives its global enable.
// PARAMETERS
//   NREQ     7  number of requesters (>=2)
//   MAX_HOLD 8  max cycles a grant may be held before forced release (1..255)
//   COOL     1  idle cycles inserted after every release (0..15; 0 = none)
// PORTS
//   clk       in   1          rising-edge clock
//   rst       in   1          synchronous, active-high reset
//   en        in   1          scheduler enable; new grants are issued only while high
//   req       in   NREQ       level requests; bit i = requester i
//   done_i    in   1          current owner finished; sampled only in GRANT
//   grant     out  NREQ       one-hot grant; all zero when nobody owns the path
//   grant_id  out  $clog2(NREQ)  index of the current owner; 0 when grant==0
//   busy      out  1          high in GRANT and in COOL
//   timeout   out  1          1-cycle pulse when a grant is force-released at MAX_HOLD
// BEHAVIOUR
//   All outputs are registered. On reset:
//     grant=0, grant_id=0, busy=0, timeout=0, rr_ptr=0, hold_cnt=0, cool_cnt=0, state=IDLE.
//   Reset asserted mid-grant clears grant at the next edge; no timeout pulse is issued.
//   FSM states: IDLE -> GRANT -> (COOL) -> IDLE.
//   IDLE
//     - If en && |req: pick the first set req bit searching upward from rr_ptr,
//       wrapping from NREQ-1 to 0.
//     - Next cycle: grant[w]=1, grant_id=w, busy=1, state=GRANT.
//     - Latency from req to grant is 1 clock.
//     - rr_ptr <= (w==NREQ-1) ? 0 : w+1.
//     - Otherwise stay in IDLE; outputs stay zero.
//   GRANT
//     - hold_cnt increments from 0 every cycle.
//     - Release when any of these holds:
//       (a) done_i=1;
//       (b) req[grant_id]=0;
//       (c) hold_cnt==MAX_HOLD-1, which also pulses timeout=1 on the following cycle.
//     - If (a) or (b) occurs in the same cycle as (c), there is no timeout pulse.
//     - On release: grant<=0, grant_id<=0, hold_cnt<=0.
//       state<=COOL if COOL>0, else state<=IDLE with busy<=0.
//     - Dropping en during GRANT does not abort the grant; it only blocks the next grant.
//   COOL
//     - grant=0, busy=1.
//     - cool_cnt counts 0..COOL-1, then state<=IDLE, busy<=0.
//     - Requests are ignored while in COOL.
//   Ordering and overlap
//     - Requests arriving during GRANT or COOL are arbitrated only on return to IDLE.
//     - With COOL=0, a back-to-back re-grant takes 2 cycles:
//       release edge, then IDLE evaluation, then grant.
//   Invariants
//     - $onehot0(grant) at all times.
//     - grant!=0 implies busy=1.
//     - timeout is never high for two consecutive cycles.
// TESTING
//   T1 reset: hold rst 3 cycles with req=7'h7F, en=1
//      -> grant=0, busy=0, timeout=0 throughout; first grant is 7'h01 one cycle after rst drops.
//   T2 round-robin: req=7'h7F steady, done_i pulsed each GRANT cycle, COOL=1
//      -> grant_id sequence 0,1,2,3,4,5,6,0; gap of 1 COOL cycle plus 1 IDLE cycle between grants.
//   T3 timeout: req=7'h08 held, done_i=0, MAX_HOLD=8
//      -> grant=7'h08 for exactly 8 cycles, timeout=1 for 1 cycle, then COOL, then re-grant of 7'h08.
//   T4 collision: done_i=1 on the same cycle hold_cnt==MAX_HOLD-1 -> release, timeout stays 0.
//   T5 enable: drop en mid-grant
//      -> current grant runs to done_i; no further grant until en=1, after which grant appears 1 cycle later.
//   T6 wrap/withdraw: rr_ptr=6, req=7'h41 -> grant 7'h40;
//      req[6] drops -> release; next grant is 7'h01 (wrap to index 0).

Source files
------------

// File: rtl/i1_req_scheduler.sv
// Round-robin scheduler for the i1 decode request lines.
// One requester owns the shared decode path at a time. Each grant is bounded
// by a hold limit and is followed by an optional cooldown. All outputs are
// registered, so a request becomes a grant one clock after it is seen in IDLE.
module i1_req_scheduler #(
  parameter int NREQ     = 7,
  parameter int MAX_HOLD = 8,
  parameter int COOL     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req,
  input  logic                    done_i,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout
);

  localparam int IDW = $clog2(NREQ);
  localparam int HW  = 8;
  localparam int CW  = 4;

  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [CW-1:0]  COOL_LAST = CW'((COOL > 0) ? (COOL - 1) : 0);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr, rr_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic [CW-1:0]   cool_cnt, cool_d;
  logic [NREQ-1:0] grant_d;
  logic [IDW-1:0]  id_d;
  logic            busy_d;
  logic            timeout_d;

  logic            found;
  logic [IDW-1:0]  pick;

  logic            rel_done;
  logic            rel_drop;
  logic            rel_max;

  // Find the first active request at or above rr_ptr, wrapping past the top index.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  // Next-state and next-output logic; every register holds unless a transition says otherwise.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_ptr;
    hold_d    = hold_cnt;
    cool_d    = cool_cnt;
    grant_d   = grant;
    id_d      = grant_id;
    busy_d    = busy;
    timeout_d = 1'b0;

    rel_done  = done_i;
    rel_drop  = ~|(req & grant);
    rel_max   = (hold_cnt == HOLD_LAST);

    case (state_q)
      S_IDLE: begin
        if (en && found) begin
          state_d = S_GRANT;
          grant_d = NREQ'(1) << pick;
          id_d    = pick;
          busy_d  = 1'b1;
          hold_d  = '0;
          rr_d    = (pick == LAST_ID) ? '0 : pick + IDW'(1);
        end
      end

      S_GRANT: begin
        if (rel_done || rel_drop || rel_max) begin
          grant_d   = '0;
          id_d      = '0;
          hold_d    = '0;
          timeout_d = rel_max && !rel_done && !rel_drop;
          if (COOL > 0) begin
            state_d = S_COOL;
            cool_d  = '0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          hold_d = hold_cnt + HW'(1);
        end
      end

      S_COOL: begin
        if (cool_cnt == COOL_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cool_d  = '0;
        end else begin
          cool_d = cool_cnt + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        id_d    = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
        cool_d  = '0;
      end
    endcase
  end

  // State and output registers; reset drops any grant without a timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      cool_cnt <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr   <= rr_d;
      hold_cnt <= hold_d;
      cool_cnt <= cool_d;
      grant    <= grant_d;
      grant_id <= id_d;
      busy     <= busy_d;
      timeout  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_i1_req_scheduler.sv
// Self-checking bench for i1_req_scheduler (NREQ=7, MAX_HOLD=8, COOL=1).
// A table of per-cycle vectors covers reset, round-robin order, timeout,
// done/timeout collision, enable gating, wrap/withdraw and mid-grant reset;
// hand-written sequences cover bounded waits, and a monitor checks invariants.
module tb_i1_req_scheduler;

  localparam int NREQ = 7;

  logic       clk;
  logic       rst;
  logic       en;
  logic [6:0] req;
  logic       done_i;
  logic [6:0] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic       timeout;

  typedef struct {
    logic       rst;
    logic       en;
    logic [6:0] req;
    logic       done_i;
    logic [6:0] exp_grant;
    logic [2:0] exp_id;
    logic       exp_busy;
    logic       exp_timeout;
  } vec_t;

  vec_t vecs[160];
  int   n_vec = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  bit   mon_en = 0;
  logic prev_timeout = 1'b0;

  i1_req_scheduler #(.NREQ(7), .MAX_HOLD(8), .COOL(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .done_i   (done_i),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic r, input logic e, input logic [6:0] q, input logic d,
                         input logic [6:0] g, input logic [2:0] id, input logic b, input logic t);
    vecs[n_vec] = '{r, e, q, d, g, id, b, t};
    n_vec++;
  endtask

  task automatic check_val(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one set of inputs away from the rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [6:0] q, input logic d);
    @(negedge clk);
    rst    = r;
    en     = e;
    req    = q;
    done_i = d;
  endtask

  // Compare all outputs a little after the edge that consumed the inputs.
  task automatic checkOutput(input int idx, input vec_t v);
    @(posedge clk);
    #1;
    check_val($sformatf("v%0d grant", idx), int'(grant), int'(v.exp_grant));
    check_val($sformatf("v%0d grant_id", idx), int'(grant_id), int'(v.exp_id));
    check_val($sformatf("v%0d busy", idx), int'(busy), int'(v.exp_busy));
    check_val($sformatf("v%0d timeout", idx), int'(timeout), int'(v.exp_timeout));
  endtask

  // Invariants sampled on the falling edge once reset has been applied.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (!$onehot0(grant)) begin
        n_fails++;
        $display("[TB] FAIL inv_onehot: grant=0x%0h not onehot0 at %0t", grant, $time);
      end
      n_checks++;
      if ((grant != 7'h00) && !busy) begin
        n_fails++;
        $display("[TB] FAIL inv_busy: grant=0x%0h busy=%0b at %0t", grant, busy, $time);
      end
      n_checks++;
      if (timeout && prev_timeout) begin
        n_fails++;
        $display("[TB] FAIL inv_timeout: timeout high 2 cycles, got 1 required 0 at %0t", $time);
      end
      prev_timeout = timeout;
    end
  end

  initial begin
    int cycles;
    int grant_cycles;
    bit seen;

    rst = 1'b1; en = 1'b0; req = '0; done_i = 1'b0;

    // T1 reset held 3 cycles with all requests, then first grant to requester 0.
    for (int i = 0; i < 3; i++) add_vec(1, 1, 7'h7F, 0, 7'h00, 0, 0, 0);
    add_vec(0, 1, 7'h7F, 0, 7'h01, 0, 1, 0);

    // T2 round-robin: release, cool, idle, next grant.
    for (int k = 1; k <= 7; k++) begin
      add_vec(0, 1, 7'h7F, 1, 7'h00, 0, 1, 0);
      add_vec(0, 1, 7'h7F, 0, 7'h00, 0, 0, 0);
      add_vec(0, 1, 7'h7F, 0, 7'(1 << (k % 7)), 3'(k % 7), 1, 0);
    end

    // T3 timeout: owner 0 withdraws, requester 3 held 8 cycles then force-released.
    add_vec(0, 1, 7'h08, 0, 7'h00, 0, 1, 0);
    add_vec(0, 1, 7'h08, 0, 7'h00, 0, 0, 0);
    add_vec(0, 1, 7'h08, 0, 7'h08, 3, 1, 0);
    for (int i = 0; i < 7; i++) add_vec(0, 1, 7'h08, 0, 7'h08, 3, 1, 0);
    add_vec(0, 1, 7'h08, 0, 7'h00, 0, 1, 1);
    add_vec(0, 1, 7'h08, 0, 7'h00, 0, 0, 0);
    add_vec(0, 1, 7'h08, 0, 7'h08, 3, 1, 0);

    // T4 collision: done on the last hold cycle releases without a timeout.
    for (int i = 0; i < 7; i++) add_vec(0, 1, 7'h08, 0, 7'h08, 3, 1, 0);
    add_vec(0, 1, 7'h08, 1, 7'h00, 0, 1, 0);
    add_vec(0, 1, 7'h08, 0, 7'h00, 0, 0, 0);

    // T5 enable dropped mid-grant: grant runs to done, no new grant until en returns.
    add_vec(0, 1, 7'h08, 0, 7'h08, 3, 1, 0);
    add_vec(0, 0, 7'h08, 0, 7'h08, 3, 1, 0);
    add_vec(0, 0, 7'h08, 0, 7'h08, 3, 1, 0);
    add_vec(0, 0, 7'h08, 1, 7'h00, 0, 1, 0);
    add_vec(0, 0, 7'h08, 0, 7'h00, 0, 0, 0);
    add_vec(0, 0, 7'h08, 0, 7'h00, 0, 0, 0);
    add_vec(0, 0, 7'h08, 0, 7'h00, 0, 0, 0);
    add_vec(0, 1, 7'h08, 0, 7'h08, 3, 1, 0);
    add_vec(0, 1, 7'h08, 1, 7'h00, 0, 1, 0);
    add_vec(0, 1, 7'h08, 0, 7'h00, 0, 0, 0);

    // T6 wrap/withdraw: move rr_ptr to 6, grant 6, withdraw, wrap to 0.
    add_vec(0, 1, 7'h20, 0, 7'h20, 5, 1, 0);
    add_vec(0, 1, 7'h20, 1, 7'h00, 0, 1, 0);
    add_vec(0, 1, 7'h41, 0, 7'h00, 0, 0, 0);
    add_vec(0, 1, 7'h41, 0, 7'h40, 6, 1, 0);
    add_vec(0, 1, 7'h01, 0, 7'h00, 0, 1, 0);
    add_vec(0, 1, 7'h01, 0, 7'h00, 0, 0, 0);
    add_vec(0, 1, 7'h01, 0, 7'h01, 0, 1, 0);

    // Reset mid-grant: grant clears, no timeout, pointer restarts at 0.
    add_vec(1, 1, 7'h7F, 0, 7'h00, 0, 0, 0);
    add_vec(0, 1, 7'h7F, 0, 7'h01, 0, 1, 0);

    for (int i = 0; i < n_vec; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].done_i);
      checkOutput(i, vecs[i]);
      mon_en = 1;
    end

    // Hand sequence: requester 0 held alone, timeout must arrive after 8 grant cycles.
    req = 7'h01;
    done_i = 1'b0;
    seen = 0;
    cycles = 0;
    grant_cycles = 1;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      cycles = c;
      if (grant == 7'h01) grant_cycles++;
      if (timeout) seen = 1;
    end
    check_val("seq_timeout_seen", int'(seen), 1);
    check_val("seq_timeout_latency", cycles, 8);
    check_val("seq_timeout_hold_cycles", grant_cycles, 8);

    // Hand sequence: enable low blocks all grants, then grant appears one edge after enable.
    en = 1'b0;
    req = 7'h7F;
    grant_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (grant != 7'h00) grant_cycles++;
    end
    check_val("seq_en_low_no_grant", grant_cycles, 0);
    check_val("seq_en_low_busy", int'(busy), 0);
    en = 1'b1;
    @(posedge clk);
    #1;
    check_val("seq_en_high_grant", int'(grant), int'(7'h02));
    check_val("seq_en_high_id", int'(grant_id), 1);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
